// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic ops, WIDTH-step shift-add MUL and restoring DIV.
// Define SEQ_ALU_ROTATE_EN to enable opcode C (ROL) and D (ROR); otherwise they are invalid opcodes.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flag
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
`ifdef SEQ_ALU_ROTATE_EN
  localparam logic [3:0] OP_ROL  = 4'hC;
  localparam logic [3:0] OP_ROR  = 4'hD;
`endif

  state_t state, next_state;

  logic             op_mul;
  logic             lt_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi, lo;
  logic [CW-1:0]    cnt;

  logic             accept, is_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_result;
  logic [3:0]       sc_flag;
  logic             sc_valid;
`ifdef SEQ_ALU_ROTATE_EN
  logic [WIDTH-1:0] rot_amt;
`endif

  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign is_iter   = (sel == OP_MUL) || (sel == OP_DIV);

  always_comb begin
    sc_result = '0;
    sc_flag   = '0;
    sc_valid  = 1'b1;
    sum       = {1'b0, a} + {1'b0, b};
`ifdef SEQ_ALU_ROTATE_EN
    rot_amt   = b % W_VAL;
`endif
    case (sel)
      OP_ADD: begin
        sc_result  = sum[WIDTH-1:0];
        sc_flag[1] = sum[WIDTH];
      end
      OP_SUB: begin
        sc_result  = a - b;
        sc_flag[3] = (a < b);
      end
      OP_SHL:  sc_result = (b >= W_VAL) ? '0 : (a << b);
      OP_SHR:  sc_result = (b >= W_VAL) ? '0 : (a >> b);
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_XNOR: sc_result = ~(a ^ b);
      OP_NAND: sc_result = ~(a & b);
      OP_NOR:  sc_result = ~(a | b);
`ifdef SEQ_ALU_ROTATE_EN
      OP_ROL:  sc_result = (a << rot_amt) | (a >> (W_VAL - rot_amt));
      OP_ROR:  sc_result = (a >> rot_amt) | (a << (W_VAL - rot_amt));
`endif
      default: sc_valid = 1'b0;
    endcase
    if (sc_valid) sc_flag[0] = (sc_result == '0);
  end

  // One iteration: MUL shifts {hi,lo} right after a conditional add; DIV shifts left and trial-subtracts.
  always_comb begin
    madd    = {1'b0, hi} + ({1'b0, b_q} & {(WIDTH+1){lo[0]}});
    shifted = {hi, lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_q});
    diff    = shifted[WIDTH-1:0] - b_q;
    if (op_mul) begin
      step_hi = madd[WIDTH:1];
      step_lo = {madd[0], lo[WIDTH-1:1]};
    end else begin
      step_hi = ge ? diff : shifted[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = is_iter ? CALC : DONE;
      CALC: if (cnt == LAST) next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_mul <= 1'b0;
      lt_q   <= 1'b0;
      b_q    <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
      flag   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_mul <= (sel == OP_MUL);
          lt_q   <= (a < b);
          b_q    <= b;
          hi     <= '0;
          lo     <= a;
          cnt    <= '0;
          if (!is_iter) begin
            result <= sc_result;
            flag   <= sc_flag;
          end
        end
        CALC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt + 1'b1;
          // Final step: flags come from the post-step values, never the previous operation's.
          if (cnt == LAST) begin
            if (op_mul) begin
              result <= step_lo;
              flag   <= {1'b0, (step_hi != '0), 1'b0, (step_lo == '0)};
            end else if (b_q == '0) begin
              result <= '1;
              flag   <= 4'b0100;
            end else begin
              result <= step_lo;
              flag   <= {lt_q, 2'b00, (step_lo == '0)};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
